// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: operand width, FUNC3 encodings and the
// multiply/divide unit state encoding.
package rv32m_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage connection between the pipeline (master) and the mul/div unit (slave).
interface ex_muldiv_unit_if;
    import rv32m_pkg::*;

    logic            EX_START;
    logic [2:0]      EX_FUNC3;
    logic [XLEN-1:0] EX_OPERAND_A;
    logic [XLEN-1:0] EX_OPERAND_B;
    logic            EX_FLUSH;
    logic            MD_BUSY;
    logic            MD_DONE;
    logic [XLEN-1:0] MD_RESULT;

    modport master (
        output EX_START, EX_FUNC3, EX_OPERAND_A, EX_OPERAND_B, EX_FLUSH,
        input  MD_BUSY, MD_DONE, MD_RESULT
    );

    modport slave (
        input  EX_START, EX_FUNC3, EX_OPERAND_A, EX_OPERAND_B, EX_FLUSH,
        output MD_BUSY, MD_DONE, MD_RESULT
    );

endinterface

// File: rtl/md_serial_divider.sv
// Unsigned 32-step restoring divider. The _c outputs carry the values being
// written on the final step so the caller can register them on that same edge.
module md_serial_divider
    import rv32m_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_c_o,
    output logic [XLEN-1:0] remainder_c_o,
    output logic            done_c_o
);

    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic [XLEN:0]    rem_shift;
    logic             ge;

    // quo_q starts as the dividend; its MSB feeds the remainder each step
    // while quotient bits shift in at the bottom.
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        done_c_o  = 1'b0;
        rem_shift = {rem_q, quo_q[XLEN-1]};
        ge        = (rem_shift >= {1'b0, dvs_q});

        if (flush_i) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (start_i) begin
            rem_d    = '0;
            quo_d    = dividend_i;
            dvs_d    = divisor_i;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            rem_d = ge ? XLEN'(rem_shift - {1'b0, dvs_q}) : rem_shift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], ge};
            if (cnt_q == CNT_W'(XLEN - 1)) begin
                done_c_o = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign quotient_c_o  = quo_d;
    assign remainder_c_o = rem_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: single-cycle multiply, serial divide with sign fix-up,
// fast paths for divide-by-zero and signed overflow, and a pipeline stall request.
module ex_muldiv_unit
    import rv32m_pkg::*;
(
    input logic               CLK,
    input logic               RST_N,
    ex_muldiv_unit_if.slave   md
);

    md_state_t       state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;
    logic            op_rem_q, op_rem_d;
    logic            quo_neg_q, quo_neg_d;
    logic            rem_neg_q, rem_neg_d;

    logic              div_start;
    logic [XLEN-1:0]   div_quo, div_rem;
    logic              div_done;
    logic              op_signed, a_neg, b_neg, mul_a_sext, mul_b_sext;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;

    // Operand conditioning for both multiply and divide, taken from the ports at E0.
    always_comb begin
        op_signed  = ~md.EX_FUNC3[0];
        a_neg      = op_signed & md.EX_OPERAND_A[XLEN-1];
        b_neg      = op_signed & md.EX_OPERAND_B[XLEN-1];
        abs_a      = a_neg ? -md.EX_OPERAND_A : md.EX_OPERAND_A;
        abs_b      = b_neg ? -md.EX_OPERAND_B : md.EX_OPERAND_B;
        mul_a_sext = (md.EX_FUNC3 == F3_MULH) || (md.EX_FUNC3 == F3_MULHSU);
        mul_b_sext = (md.EX_FUNC3 == F3_MULH);
        mul_a      = {{XLEN{mul_a_sext & md.EX_OPERAND_A[XLEN-1]}}, md.EX_OPERAND_A};
        mul_b      = {{XLEN{mul_b_sext & md.EX_OPERAND_B[XLEN-1]}}, md.EX_OPERAND_B};
        prod       = mul_a * mul_b;
    end

    md_serial_divider u_div (
        .clk           (CLK),
        .rst_n         (RST_N),
        .start_i       (div_start),
        .flush_i       (md.EX_FLUSH),
        .dividend_i    (abs_a),
        .divisor_i     (abs_b),
        .quotient_c_o  (div_quo),
        .remainder_c_o (div_rem),
        .done_c_o      (div_done)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        done_d    = 1'b0;
        op_rem_d  = op_rem_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        div_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (md.EX_START && !md.EX_FLUSH) begin
                    op_rem_d  = md.EX_FUNC3[1];
                    quo_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    state_d   = DONE;
                    done_d    = 1'b1;
                    if (!md.EX_FUNC3[2]) begin
                        result_d = (md.EX_FUNC3 == F3_MUL) ? prod[XLEN-1:0]
                                                           : prod[2*XLEN-1:XLEN];
                    end else if (md.EX_OPERAND_B == '0) begin
                        result_d = md.EX_FUNC3[1] ? md.EX_OPERAND_A : '1;
                    end else if (op_signed && md.EX_OPERAND_A == {1'b1, {(XLEN-1){1'b0}}}
                                 && md.EX_OPERAND_B == '1) begin
                        result_d = md.EX_FUNC3[1] ? '0 : md.EX_OPERAND_A;
                    end else begin
                        div_start = 1'b1;
                        state_d   = DIV;
                        done_d    = 1'b0;
                    end
                end
            end
            DIV: begin
                if (md.EX_FLUSH) begin
                    state_d = IDLE;
                end else if (div_done) begin
                    result_d = op_rem_q ? (rem_neg_q ? -div_rem : div_rem)
                                        : (quo_neg_q ? -div_quo : div_quo);
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            result_q  <= '0;
            done_q    <= 1'b0;
            op_rem_q  <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            done_q    <= done_d;
            op_rem_q  <= op_rem_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

    // No stall request while held in reset.
    assign md.MD_BUSY   = RST_N & ~md.EX_FLUSH &
                          (((state_q == IDLE) & md.EX_START) | (state_q == DIV));
    assign md.MD_DONE   = done_q;
    assign md.MD_RESULT = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M vectors, latency,
// flush and mid-operation reset.
module tb_ex_muldiv_unit;
    import rv32m_pkg::*;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    ex_muldiv_unit_if md ();

    ex_muldiv_unit dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .md    (md)
    );

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    int          n_push   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every MD_DONE pops one expected result.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && md.MD_DONE === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got result 0x%08h, expected no completion",
                         md.MD_RESULT);
            end else begin
                check(name_q.pop_front(), md.MD_RESULT, exp_q.pop_front());
            end
        end
    end

    // Issue an op at the current (post-negedge) time; returns in the DONE cycle.
    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_busy);
        int busy_n = 0;
        md.EX_START     = 1'b1;
        md.EX_FUNC3     = f3;
        md.EX_OPERAND_A = a;
        md.EX_OPERAND_B = b;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        n_push++;
        #1;
        while (md.MD_BUSY === 1'b1 && busy_n < 100) begin
            busy_n++;
            @(negedge CLK);
            #1;
        end
        check({nm, " busy_cycles"}, 32'(busy_n), 32'(exp_busy));
        check({nm, " done_latency"}, 32'(md.MD_DONE), 32'd1);
    endtask

    task automatic finish_op(input string nm);
        md.EX_START = 1'b0;
        @(negedge CLK);
        #1;
        check({nm, " done_drops"}, 32'(md.MD_DONE), 32'd0);
        check({nm, " busy_idle"}, 32'(md.MD_BUSY), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        RST_N           = 1'b0;
        md.EX_START     = 1'b0;
        md.EX_FUNC3     = 3'b000;
        md.EX_OPERAND_A = '0;
        md.EX_OPERAND_B = '0;
        md.EX_FLUSH     = 1'b0;
        #1;
        check("reset result", md.MD_RESULT, 32'h0);
        check("reset done", 32'(md.MD_DONE), 32'd0);
        check("reset busy", 32'(md.MD_BUSY), 32'd0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        #1;

        run_op("MUL 7*-3", F3_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1);
        finish_op("MUL 7*-3");
        run_op("MULH", F3_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 1);
        finish_op("MULH");
        run_op("MULHU", F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
        finish_op("MULHU");
        run_op("MULHSU", F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        finish_op("MULHSU");
        run_op("DIV -7/2", F3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        finish_op("DIV -7/2");
        run_op("REM -7/2", F3_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        finish_op("REM -7/2");
        run_op("DIVU 20/3", F3_DIVU, 32'd20, 32'd3, 32'd6, 33);
        finish_op("DIVU 20/3");
        run_op("REMU 20/3", F3_REMU, 32'd20, 32'd3, 32'd2, 33);
        finish_op("REMU 20/3");
        run_op("DIVU 100/0", F3_DIVU, 32'd100, 32'd0, 32'hFFFFFFFF, 1);
        finish_op("DIVU 100/0");
        run_op("REMU 100/0", F3_REMU, 32'd100, 32'd0, 32'd100, 1);
        finish_op("REMU 100/0");

        // Flush in the middle of a divide: no completion, result kept.
        md.EX_START     = 1'b1;
        md.EX_FUNC3     = F3_DIVU;
        md.EX_OPERAND_A = 32'd20;
        md.EX_OPERAND_B = 32'd3;
        repeat (10) @(negedge CLK);
        #1;
        md.EX_FLUSH = 1'b1;
        #1;
        check("flush busy", 32'(md.MD_BUSY), 32'd0);
        @(negedge CLK);
        #1;
        md.EX_FLUSH = 1'b0;
        md.EX_START = 1'b0;
        check("flush no_done", 32'(md.MD_DONE), 32'd0);
        check("flush result_kept", md.MD_RESULT, 32'd100);
        repeat (40) @(negedge CLK);
        #1;
        check("flush result_still_kept", md.MD_RESULT, 32'd100);
        run_op("DIVU 20/3 after flush", F3_DIVU, 32'd20, 32'd3, 32'd6, 33);
        finish_op("DIVU 20/3 after flush");

        run_op("DIV ovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        finish_op("DIV ovf");
        run_op("REM ovf", F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
        finish_op("REM ovf");
        run_op("MUL pre-reset", F3_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1);
        finish_op("MUL pre-reset");

        // Reset in the middle of a divide.
        md.EX_START     = 1'b1;
        md.EX_FUNC3     = F3_DIVU;
        md.EX_OPERAND_A = 32'd20;
        md.EX_OPERAND_B = 32'd3;
        repeat (6) @(negedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("midreset result", md.MD_RESULT, 32'h0);
        check("midreset done", 32'(md.MD_DONE), 32'd0);
        check("midreset busy", 32'(md.MD_BUSY), 32'd0);
        md.EX_START = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        RST_N = 1'b1;
        @(negedge CLK);
        #1;

        run_op("MUL 3*4", F3_MUL, 32'd3, 32'd4, 32'd12, 1);
        @(negedge CLK);
        #1;
        run_op("DIV 12/4 back-to-back", F3_DIV, 32'd12, 32'd4, 32'd3, 33);
        finish_op("DIV 12/4 back-to-back");

        repeat (5) @(negedge CLK);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_push));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
